// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and output decode for the memory access controller.
// The controller and any reuse of its wait timer import this package.
package mem_access_ctrl_pkg;

    localparam int unsigned TIMEOUT_W_DEFAULT = 4;
    localparam int unsigned TIMEOUT_DEFAULT   = 15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_MAR = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RD_LATCH = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        logic mar_in;
        logic mdr_sel;
        logic mdr_in;
        logic mem_read;
        logic mem_write;
        logic busy;
        logic done;
        logic timeout_err;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_IDLE = '{
        mar_in: 1'b0, mdr_sel: 1'b0, mdr_in: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, busy: 1'b0, done: 1'b0, timeout_err: 1'b0
    };

    // Moore output table: every strobe is a pure function of the state.
    function automatic ctrl_out_t decode_outputs(input state_e st);
        ctrl_out_t o;
        o = CTRL_OUT_IDLE;
        case (st)
            S_IDLE: begin
                o = CTRL_OUT_IDLE;
            end
            S_LOAD_MAR: begin
                o.mar_in = 1'b1;
                o.busy   = 1'b1;
            end
            S_RD_WAIT: begin
                o.mdr_sel  = 1'b1;
                o.mem_read = 1'b1;
                o.busy     = 1'b1;
            end
            S_RD_LATCH: begin
                o.mdr_sel  = 1'b1;
                o.mdr_in   = 1'b1;
                o.mem_read = 1'b1;
                o.busy     = 1'b1;
            end
            S_WR_WAIT: begin
                o.mem_write = 1'b1;
                o.busy      = 1'b1;
            end
            S_DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            S_ERR: begin
                o.busy        = 1'b1;
                o.done        = 1'b1;
                o.timeout_err = 1'b1;
            end
            default: begin
                o = CTRL_OUT_IDLE;
            end
        endcase
        return o;
    endfunction

    function automatic logic is_wait_state(input state_e st);
        return (st == S_RD_WAIT) || (st == S_WR_WAIT);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the control unit / memory side and the controller.
// The controller uses the slave view; requesters and memory drive the master view.
interface mem_access_ctrl_if #(
    parameter int unsigned TIMEOUT_W = 4
);
    logic                 req_read;
    logic                 req_write;
    logic                 mem_ready;
    logic                 mar_in;
    logic                 MDR_read;
    logic                 mdr_in;
    logic                 mem_read;
    logic                 mem_write;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;
    logic [TIMEOUT_W-1:0] wait_count;

    modport master (
        output req_read, req_write, mem_ready,
        input  mar_in, MDR_read, mdr_in, mem_read, mem_write,
        input  busy, done, timeout_err, wait_count
    );

    modport slave (
        input  req_read, req_write, mem_ready,
        output mar_in, MDR_read, mdr_in, mem_read, mem_write,
        output busy, done, timeout_err, wait_count
    );
endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// Saturating wait-state counter with clear and enable; expired_o flags count == LIMIT.
// Generic enough to bound any ready/valid style handshake.
module mem_access_ctrl_wait_timer #(
    parameter int unsigned W     = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         expired_o
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0] ONE_V   = W'(1'b1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority, then a saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT_V)) begin
            count_d = count_q + ONE_V;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_access_ctrl.sv
// Moore FSM sequencing one CPU memory transaction: MAR load, memory strobe,
// ready wait bounded by a timeout, MDR latch on reads, then done/error pulse.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);

    state_e    state_q;
    state_e    state_d;
    op_e       op_q;
    op_e       op_d;
    ctrl_out_t out_q;

    logic                 tmr_clr_s;
    logic                 tmr_en_s;
    logic                 tmr_expired_s;
    logic [TIMEOUT_W-1:0] tmr_count_s;

    // Counter restarts for every transaction and only runs while memory stalls.
    assign tmr_clr_s = (state_q == S_LOAD_MAR);
    assign tmr_en_s  = is_wait_state(state_q) && !bus.mem_ready;

    mem_access_ctrl_wait_timer #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clock),
        .rst_i     (reset),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .count_o   (tmr_count_s),
        .expired_o (tmr_expired_s)
    );

    // Next-state logic; mem_ready is checked before expiry so a late ready still completes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_read) begin
                    state_d = S_LOAD_MAR;
                    op_d    = OP_READ;
                end else if (bus.req_write) begin
                    state_d = S_LOAD_MAR;
                    op_d    = OP_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_MAR: begin
                if (op_q == OP_READ) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = S_RD_LATCH;
                end else if (tmr_expired_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_LATCH: begin
                state_d = S_DONE;
            end
            S_WR_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = S_DONE;
                end else if (tmr_expired_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, op and output registers; outputs are the decode of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            out_q   <= CTRL_OUT_IDLE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= decode_outputs(state_d);
        end
    end

    assign bus.mar_in      = out_q.mar_in;
    assign bus.MDR_read    = out_q.mdr_sel;
    assign bus.mdr_in      = out_q.mdr_in;
    assign bus.mem_read    = out_q.mem_read;
    assign bus.mem_write   = out_q.mem_write;
    assign bus.busy        = out_q.busy;
    assign bus.done        = out_q.done;
    assign bus.timeout_err = out_q.timeout_err;
    assign bus.wait_count  = tmr_count_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected output vectors per cycle are
// hand-derived from the state table and the documented latencies.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Output vector order: {mar_in, MDR_read, mdr_in, mem_read, mem_write, busy, done, timeout_err}
    localparam logic [7:0] V_IDLE   = 8'h00;
    localparam logic [7:0] V_LOAD   = 8'h84;
    localparam logic [7:0] V_RDWAIT = 8'h54;
    localparam logic [7:0] V_RDLAT  = 8'h74;
    localparam logic [7:0] V_WRWAIT = 8'h0C;
    localparam logic [7:0] V_DONE   = 8'h06;
    localparam logic [7:0] V_ERR    = 8'h07;

    mem_access_ctrl_if #(.TIMEOUT_W(4)) bus_if ();

    mem_access_ctrl #(
        .TIMEOUT_W (4),
        .TIMEOUT   (15)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus_if.mar_in, bus_if.MDR_read, bus_if.mdr_in, bus_if.mem_read,
                bus_if.mem_write, bus_if.busy, bus_if.done, bus_if.timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus_if.req_read  = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.mem_ready = 1'b0;
        tick();
        tick();
        chk("reset_outs", outs(), V_IDLE);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) tick();
        chk("idle_outs", outs(), V_IDLE);
        chk("idle_wc", 8'(bus_if.wait_count), 8'd0);

        // Zero-wait read
        bus_if.mem_ready = 1'b1;
        bus_if.req_read  = 1'b1;
        tick();
        chk("rd0_load", outs(), V_LOAD);
        bus_if.req_read = 1'b0;
        tick();
        chk("rd0_wait", outs(), V_RDWAIT);
        chk("rd0_wc", 8'(bus_if.wait_count), 8'd0);
        tick();
        chk("rd0_latch", outs(), V_RDLAT);
        tick();
        chk("rd0_done", outs(), V_DONE);
        bus_if.mem_ready = 1'b0;
        tick();
        chk("rd0_idle", outs(), V_IDLE);

        // Write with ready arriving in the fourth wait cycle
        bus_if.req_write = 1'b1;
        tick();
        chk("wr3_load", outs(), V_LOAD);
        bus_if.req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wr3_wait%0d", i), outs(), V_WRWAIT);
            chk($sformatf("wr3_wc%0d", i), 8'(bus_if.wait_count), 8'(i));
            if (i == 3) bus_if.mem_ready = 1'b1;
        end
        tick();
        chk("wr3_done", outs(), V_DONE);
        bus_if.mem_ready = 1'b0;
        tick();
        chk("wr3_idle", outs(), V_IDLE);

        // Read timeout
        bus_if.req_read = 1'b1;
        tick();
        chk("to_load", outs(), V_LOAD);
        bus_if.req_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("to_wait%0d", i), outs(), V_RDWAIT);
            chk($sformatf("to_wc%0d", i), 8'(bus_if.wait_count), 8'(i));
        end
        tick();
        chk("to_err", outs(), V_ERR);
        chk("to_err_wc", 8'(bus_if.wait_count), 8'd15);
        tick();
        chk("to_idle", outs(), V_IDLE);

        // Ready arrives exactly at wait_count == 15
        bus_if.req_read = 1'b1;
        tick();
        chk("race_load", outs(), V_LOAD);
        bus_if.req_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("race_wait%0d", i), outs(), V_RDWAIT);
            chk($sformatf("race_wc%0d", i), 8'(bus_if.wait_count), 8'(i));
            if (i == 15) bus_if.mem_ready = 1'b1;
        end
        tick();
        chk("race_latch", outs(), V_RDLAT);
        bus_if.mem_ready = 1'b0;
        tick();
        chk("race_done", outs(), V_DONE);
        tick();
        chk("race_idle", outs(), V_IDLE);

        // Simultaneous requests: read wins, write pulses while busy are dropped
        bus_if.req_read  = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.mem_ready = 1'b1;
        tick();
        chk("both_load", outs(), V_LOAD);
        bus_if.req_read = 1'b0;
        tick();
        chk("both_rdwait", outs(), V_RDWAIT);
        tick();
        chk("both_latch", outs(), V_RDLAT);
        bus_if.req_write = 1'b0;
        tick();
        chk("both_done", outs(), V_DONE);
        tick();
        chk("both_idle0", outs(), V_IDLE);
        tick();
        chk("both_idle1", outs(), V_IDLE);

        // Held write request restarts right after DONE
        bus_if.req_write = 1'b1;
        tick();
        chk("hold_load0", outs(), V_LOAD);
        tick();
        chk("hold_wrwait", outs(), V_WRWAIT);
        tick();
        chk("hold_done", outs(), V_DONE);
        tick();
        chk("hold_idle", outs(), V_IDLE);
        tick();
        chk("hold_load1", outs(), V_LOAD);
        bus_if.req_write = 1'b0;
        tick();
        chk("hold_wrwait1", outs(), V_WRWAIT);
        tick();
        chk("hold_done1", outs(), V_DONE);
        bus_if.mem_ready = 1'b0;
        tick();
        chk("hold_idle1", outs(), V_IDLE);

        // Reset in the middle of a read wait
        bus_if.req_read = 1'b1;
        tick();
        chk("rst_load", outs(), V_LOAD);
        bus_if.req_read = 1'b0;
        tick();
        chk("rst_wait0", outs(), V_RDWAIT);
        tick();
        chk("rst_wait1", outs(), V_RDWAIT);
        chk("rst_wc1", 8'(bus_if.wait_count), 8'd1);
        rst = 1'b1;
        tick();
        chk("rst_outs", outs(), V_IDLE);
        chk("rst_wc", 8'(bus_if.wait_count), 8'd0);
        rst = 1'b0;
        tick();
        chk("rst_after", outs(), V_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Moore FSM that sequences one CPU memory transaction at a time.
- Drives the MAR load, the MDR input-select and load strobes, and the memory read/write strobes.
- Waits on a memory ready handshake and bounds the wait with a timeout.
- Sits between the control unit (requesters) and the MAR/MDR datapath plus memory.

Parameters:
- TIMEOUT_W, 4, width of the wait-state counter.
- TIMEOUT, 15, max wait cycles without mem_ready before abort; must be 1..2^TIMEOUT_W-1.

Ports:
- clock  in  1  system clock, all state changes on posedge.
- reset  in  1  synchronous, active-high; forces IDLE.
- req_read  in  1  read request, sampled only in IDLE.
- req_write  in  1  write request, sampled only in IDLE; write data already held in MDR.
- mem_ready  in  1  memory handshake: data valid (read) or write accepted.
- mar_in  out  1  MAR load strobe.
- MDR_read  out  1  MDR input select: 1 = mdata_in (memory), 0 = bus.
- mdr_in  out  1  MDR load strobe.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle pulse on an aborted transaction.
- wait_count  out  TIMEOUT_W  current wait-state count, for debug.

Behaviour:
- States: IDLE, LOAD_MAR, RD_WAIT, RD_LATCH, WR_WAIT, DONE, ERR.
- All outputs are decoded from registered state (Moore); no combinational path from any input to any output.
- Reset: state = IDLE, op = read, wait_count = 0. Every output is 0 in the cycle after reset is sampled high, including when reset arrives mid-transaction. Any in-flight access is dropped; mem_read/mem_write deassert immediately.
- IDLE:
  - req_read -> LOAD_MAR with op = read.
  - Else req_write -> LOAD_MAR with op = write.
  - Both high together: read wins; the write is not remembered.
  - Neither high: stay in IDLE.
- LOAD_MAR: mar_in = 1 for exactly one cycle; wait_count cleared to 0. Next state RD_WAIT (op = read) or WR_WAIT (op = write).
- RD_WAIT:
  - Outputs: mem_read = 1, MDR_read = 1.
  - mem_ready = 1 -> RD_LATCH.
  - Else if wait_count == TIMEOUT -> ERR.
  - Else wait_count increments.
- RD_LATCH: mem_read = 1, MDR_read = 1, mdr_in = 1 for one cycle; next state DONE.
- WR_WAIT:
  - Outputs: mem_write = 1, MDR_read = 0.
  - mem_ready = 1 -> DONE.
  - Else timeout check as in RD_WAIT -> ERR.
- DONE: done = 1 for one cycle; next state IDLE.
- ERR: timeout_err = 1 and done = 1 for one cycle; next state IDLE. MDR is never loaded on a timed-out read.
- Simultaneous mem_ready and wait_count == TIMEOUT: mem_ready wins and the transaction completes normally.
- Counter: increments only in the wait states; saturates at TIMEOUT and never wraps.
- Requests outside IDLE are ignored; there is no queue. A requester holding its request through DONE gets a new transaction starting the cycle after DONE.
- mem_ready outside the wait states is ignored.
- Latency, zero wait states (mem_ready high on the first RD_WAIT cycle):
  - Read: request sampled at edge N; mar_in high N+1, mem_read high N+2..N+3, mdr_in high N+3, done high N+4.
  - Write: mar_in high N+1, mem_write high N+2, done high N+3.
- Latency grows by one cycle per additional wait cycle.

Decomposition:
- Shared package holds:
  - State encoding constants, 3-bit: IDLE = 0, LOAD_MAR = 1, RD_WAIT = 2, RD_LATCH = 3, WR_WAIT = 4, DONE = 5, ERR = 6.
  - Op constants: OP_READ = 0, OP_WRITE = 1.
  - Default TIMEOUT.
- One sub-module, wait_timer, is natural: a saturating counter with clear, enable and an "expired" flag for wait_count == TIMEOUT, reusable for other bus handshakes.
- The FSM stays in mem_access_ctrl.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, busy 0, wait_count 0.
- Read, mem_ready already high -> mar_in at N+1, mem_read at N+2..N+3, MDR_read 1 and mdr_in 1 at N+3, done at N+4, timeout_err 0.
- Write with mem_ready delayed 3 cycles -> mem_write high 4 cycles with MDR_read 0, mdr_in never high, done one cycle after mem_ready is seen.
- Read with no mem_ready, TIMEOUT = 15 -> wait_count reaches 15, then ERR with timeout_err and done pulsing together, mdr_in never high, back to IDLE.
- Arrival race: mem_ready first arrives in the cycle wait_count == 15 -> normal RD_LATCH and DONE, timeout_err stays 0.
- Contention and reset:
  - req_read and req_write high together -> read performed; req_write pulses during busy are ignored.
  - reset asserted during RD_WAIT -> next cycle IDLE with mem_read 0 and busy 0.
